aes_axi_seq_master: RTL and testbench

// - AXI4-Lite master that runs one AES-128 job on the AES IP slave, the IP's direct upstream feeder.
// - Takes key + plaintext on a valid/ready request port.
// - Performs the register write / start / status-poll / result-read sequence over AXI4-Lite.
// - Returns the ciphertext, or an error flag, on a valid/ready response port.

---
 rtl/aes_axi_seq_master.sv | 233 +++++++++++++++++++++++
 tb/tb_aes_axi_seq_master.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_axi_seq_master.sv
`default_nettype none
// ============================================================================
// Module  : aes_axi_seq_master
// Brief   : AXI4-Lite master that drives one AES-128 job on the AES IP slave.
//           It loads the key and plaintext, starts the core, polls for done,
//           reads the ciphertext back and returns it (or an error) on a
//           valid/ready response port.
// Revision: 1.0 - initial release
// ============================================================================
module aes_axi_seq_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned POLL_MAX  = 1024
) (
  input  logic         ACLK,
  input  logic         ARST,
  // job request
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [127:0] req_key,
  input  logic [127:0] req_data,
  // job response
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  // AXI4-Lite write channels
  output logic [31:0]  AWADDR,
  output logic         AWVALID,
  input  logic         AWREADY,
  output logic [31:0]  WDATA,
  output logic [3:0]   WSTRB,
  output logic         WVALID,
  input  logic         WREADY,
  input  logic [1:0]   BRESP,
  input  logic         BVALID,
  output logic         BREADY,
  // AXI4-Lite read channels
  output logic [31:0]  ARADDR,
  output logic         ARVALID,
  input  logic         ARREADY,
  input  logic [31:0]  RDATA,
  input  logic [1:0]   RRESP,
  input  logic         RVALID,
  output logic         RREADY
);

  localparam int unsigned      c_PW        = $clog2(POLL_MAX + 1);
  localparam logic [c_PW-1:0]  c_POLL_LAST = c_PW'(POLL_MAX - 1);
  localparam logic [c_PW-1:0]  c_POLL_ONE  = c_PW'(1);

  localparam logic [31:0] c_OFF_KEY  = 32'h0000_0000;
  localparam logic [31:0] c_OFF_DIN  = 32'h0000_0010;
  localparam logic [31:0] c_OFF_CTRL = 32'h0000_0020;
  localparam logic [31:0] c_OFF_STAT = 32'h0000_0024;
  localparam logic [31:0] c_OFF_DOUT = 32'h0000_0030;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_KEY  = 3'd1,
    S_WR_DIN  = 3'd2,
    S_WR_CTRL = 3'd3,
    S_POLL    = 3'd4,
    S_RD_DOUT = 3'd5,
    S_RSP     = 3'd6
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [127:0]    r_key;
  logic [127:0]    r_din;
  logic [127:0]    r_dout;
  logic            r_err;
  logic [1:0]      r_idx;        // word index within KEY/DIN/DOUT
  logic            r_resp_phase; // 0: address/data phase, 1: waiting for B/R
  logic            r_aw_done;
  logic            r_w_done;
  logic [c_PW-1:0] r_poll_cnt;
  logic            r_req_ready;

  logic        w_is_wr, w_is_rd, w_last_word;
  logic        w_req_hs, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic        w_b_err, w_r_err;
  logic [31:0] w_wr_off, w_rd_off, w_wdata;

  assign w_is_wr     = (r_state == S_WR_KEY) || (r_state == S_WR_DIN) || (r_state == S_WR_CTRL);
  assign w_is_rd     = (r_state == S_POLL) || (r_state == S_RD_DOUT);
  assign w_last_word = (r_idx == 2'd3);

  // AXI channel outputs follow directly from the registered transaction phase
  assign AWVALID = w_is_wr & ~r_resp_phase & ~r_aw_done;
  assign WVALID  = w_is_wr & ~r_resp_phase & ~r_w_done;
  assign BREADY  = w_is_wr &  r_resp_phase;
  assign ARVALID = w_is_rd & ~r_resp_phase;
  assign RREADY  = w_is_rd &  r_resp_phase;
  assign AWADDR  = w_is_wr ? (BASE_ADDR + w_wr_off) : 32'h0;
  assign WDATA   = w_is_wr ? w_wdata : 32'h0;
  assign WSTRB   = 4'hF;
  assign ARADDR  = w_is_rd ? (BASE_ADDR + w_rd_off) : 32'h0;

  assign req_ready = r_req_ready;
  assign rsp_valid = (r_state == S_RSP);
  assign rsp_data  = rsp_valid ? r_dout : 128'h0;
  assign rsp_err   = rsp_valid & r_err;

  assign w_req_hs = req_valid & r_req_ready & (r_state == S_IDLE);
  assign w_aw_hs  = AWVALID & AWREADY;
  assign w_w_hs   = WVALID & WREADY;
  assign w_b_hs   = BREADY & BVALID;
  assign w_ar_hs  = ARVALID & ARREADY;
  assign w_r_hs   = RREADY & RVALID;
  assign w_b_err  = (BRESP != 2'b00);
  assign w_r_err  = (RRESP != 2'b00);

  // Register offsets and write data for the current step
  always_comb begin
    w_wr_off = c_OFF_CTRL;
    w_rd_off = c_OFF_STAT;
    w_wdata  = 32'h0000_0001;
    case (r_state)
      S_WR_KEY: begin
        w_wr_off = c_OFF_KEY | {28'h0, r_idx, 2'b00};
        w_wdata  = r_key[{r_idx, 5'b0} +: 32];
      end
      S_WR_DIN: begin
        w_wr_off = c_OFF_DIN | {28'h0, r_idx, 2'b00};
        w_wdata  = r_din[{r_idx, 5'b0} +: 32];
      end
      S_RD_DOUT: w_rd_off = c_OFF_DOUT | {28'h0, r_idx, 2'b00};
      default: ;
    endcase
  end

  // Next-state logic: advance on each B/R handshake, abort to RSP on error
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_req_hs) w_state_next = S_WR_KEY;
      S_WR_KEY:  if (w_b_hs) w_state_next = w_b_err ? S_RSP : (w_last_word ? S_WR_DIN : S_WR_KEY);
      S_WR_DIN:  if (w_b_hs) w_state_next = w_b_err ? S_RSP : (w_last_word ? S_WR_CTRL : S_WR_DIN);
      S_WR_CTRL: if (w_b_hs) w_state_next = w_b_err ? S_RSP : S_POLL;
      S_POLL: begin
        if (w_r_hs) begin
          if (w_r_err)                         w_state_next = S_RSP;
          else if (RDATA[0])                   w_state_next = S_RD_DOUT;
          else if (r_poll_cnt == c_POLL_LAST)  w_state_next = S_RSP;
        end
      end
      S_RD_DOUT: if (w_r_hs) w_state_next = (w_r_err || w_last_word) ? S_RSP : S_RD_DOUT;
      S_RSP:     if (rsp_ready) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Job operands, transaction phase tracking, poll counter and result capture
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      r_key        <= 128'h0;
      r_din        <= 128'h0;
      r_dout       <= 128'h0;
      r_err        <= 1'b0;
      r_idx        <= 2'd0;
      r_resp_phase <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_poll_cnt   <= '0;
      r_req_ready  <= 1'b0;
    end else begin
      r_req_ready <= (w_state_next == S_IDLE);

      if (w_req_hs) begin
        r_key        <= req_key;
        r_din        <= req_data;
        r_dout       <= 128'h0;
        r_err        <= 1'b0;
        r_idx        <= 2'd0;
        r_resp_phase <= 1'b0;
        r_aw_done    <= 1'b0;
        r_w_done     <= 1'b0;
        r_poll_cnt   <= '0;
      end

      // AW and W may complete in different cycles; wait for both
      if (w_is_wr && !r_resp_phase) begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
          r_resp_phase <= 1'b1;
          r_aw_done    <= 1'b0;
          r_w_done     <= 1'b0;
        end
      end

      if (w_is_rd && !r_resp_phase && w_ar_hs) r_resp_phase <= 1'b1;

      // Word index restarts whenever the step changes
      if (w_b_hs || w_r_hs) begin
        r_resp_phase <= 1'b0;
        r_idx        <= (w_state_next == r_state) ? r_idx + 2'd1 : 2'd0;
      end

      if (w_b_hs && w_b_err) begin
        r_err  <= 1'b1;
        r_dout <= 128'h0;
      end

      if (w_r_hs) begin
        if (w_r_err) begin
          r_err  <= 1'b1;
          r_dout <= 128'h0;
        end else if (r_state == S_POLL) begin
          if (!RDATA[0]) begin
            r_poll_cnt <= r_poll_cnt + c_POLL_ONE;
            if (r_poll_cnt == c_POLL_LAST) begin
              r_err  <= 1'b1;
              r_dout <= 128'h0;
            end
          end
        end else begin
          r_dout[{r_idx, 5'b0} +: 32] <= RDATA;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_axi_seq_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_axi_seq_master
// Brief   : Directed self-checking bench for aes_axi_seq_master with a
//           behavioural AXI4-Lite AES slave.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aes_axi_seq_master;

  localparam logic [31:0] c_BASE = 32'h4000_0000;
  localparam int          c_PMAX = 8;

  logic         ACLK = 1'b0;
  logic         ARST = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [127:0] req_key = '0;
  logic [127:0] req_data = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_data;
  logic         rsp_err;
  logic [31:0]  AWADDR;
  logic         AWVALID;
  logic         AWREADY = 1'b0;
  logic [31:0]  WDATA;
  logic [3:0]   WSTRB;
  logic         WVALID;
  logic         WREADY = 1'b0;
  logic [1:0]   BRESP = 2'b00;
  logic         BVALID = 1'b0;
  logic         BREADY;
  logic [31:0]  ARADDR;
  logic         ARVALID;
  logic         ARREADY = 1'b0;
  logic [31:0]  RDATA = '0;
  logic [1:0]   RRESP = 2'b00;
  logic         RVALID = 1'b0;
  logic         RREADY;

  aes_axi_seq_master #(.BASE_ADDR(c_BASE), .POLL_MAX(c_PMAX)) dut (
    .ACLK(ACLK), .ARST(ARST),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  // slave configuration and logs
  bit           w_early = 0;
  int           done_on = 1;     // 0 = never done
  bit           bresp_ctrl_err = 0;
  logic [127:0] ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic [31:0]  wr_addr [0:31];
  logic [31:0]  wr_data [0:31];
  logic [31:0]  rd_addr [0:31];
  int           wr_cnt = 0, rd_cnt = 0, stat_reads = 0, wstrb_bad = 0;

  logic [31:0]  exp_wa [0:8];
  logic [31:0]  exp_wd [0:8];
  logic [127:0] key_v = 128'h000102030405060708090a0b0c0d0e0f;
  logic [127:0] pt_v  = 128'h00112233445566778899aabbccddeeff;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // AXI4-Lite slave: sample handshakes at negedge, update outputs just after posedge
  initial begin : slave
    bit s_aw, s_w, s_b, s_ar, s_r, have_aw, have_w;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    int aw_wait, idx;
    have_aw = 0; have_w = 0; aw_wait = 0;
    p_awaddr = '0; p_wdata = '0; p_araddr = '0;
    forever begin
      @(negedge ACLK);
      s_aw = AWVALID && AWREADY;
      s_w  = WVALID && WREADY;
      s_b  = BVALID && BREADY;
      s_ar = ARVALID && ARREADY;
      s_r  = RVALID && RREADY;
      if (s_aw) begin p_awaddr = AWADDR; have_aw = 1; end
      if (s_w) begin
        p_wdata = WDATA; have_w = 1;
        if (WSTRB !== 4'hF) wstrb_bad++;
      end
      if (s_ar) p_araddr = ARADDR;
      if (AWVALID && !AWREADY) aw_wait++;
      @(posedge ACLK);
      #1;
      if (ARST) begin
        BVALID = 0; RVALID = 0; have_aw = 0; have_w = 0; aw_wait = 0;
        continue;
      end
      if (s_b) BVALID = 0;
      if (s_r) RVALID = 0;
      if (have_aw && have_w) begin
        if (wr_cnt < 32) begin wr_addr[wr_cnt] = p_awaddr; wr_data[wr_cnt] = p_wdata; end
        wr_cnt++;
        BRESP  = (bresp_ctrl_err && p_awaddr == c_BASE + 32'h20) ? 2'b10 : 2'b00;
        BVALID = 1;
        have_aw = 0; have_w = 0;
      end
      if (s_ar) begin
        if (rd_cnt < 32) rd_addr[rd_cnt] = p_araddr;
        rd_cnt++;
        RRESP = 2'b00;
        if (p_araddr == c_BASE + 32'h24) begin
          stat_reads++;
          RDATA = (done_on != 0 && stat_reads >= done_on) ? 32'h0000_0001 : 32'hFFFF_FFFE;
        end else if (p_araddr >= c_BASE + 32'h30 && p_araddr <= c_BASE + 32'h3C) begin
          idx = int'((p_araddr - c_BASE - 32'h30) >> 2);
          RDATA = ct[32*idx +: 32];
        end else begin
          RDATA = 32'hDEAD_BEEF;
        end
        RVALID = 1;
      end
      if (w_early) begin
        WREADY = 1;
        if (s_aw) aw_wait = 0;
        AWREADY = (aw_wait >= 3);
      end else begin
        AWREADY = 1; WREADY = 1; aw_wait = 0;
      end
      ARREADY = 1;
    end
  end

  task automatic clear_logs();
    wr_cnt = 0; rd_cnt = 0; stat_reads = 0;
  endtask

  // Issue one job, wait for the response, optionally hold rsp_ready low, then accept
  task automatic run_job(input string tag, input logic [127:0] exp_d, input logic exp_e,
                         input int exp_lat, input int hold);
    int n;
    @(negedge ACLK);
    req_key = key_v; req_data = pt_v; req_valid = 1;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge ACLK); n++; end
    check({tag, "_req_ready"}, req_ready, 1'b1);
    @(posedge ACLK);
    #1 req_valid = 0;
    n = 1;
    @(negedge ACLK);
    while (!rsp_valid && n < 2000) begin @(negedge ACLK); n++; end
    check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    if (exp_lat > 0) check({tag, "_latency"}, n, exp_lat);
    check({tag, "_rsp_data"}, rsp_data, exp_d);
    check({tag, "_rsp_err"}, rsp_err, exp_e);
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      check($sformatf("%s_hold%0d", tag, i), {rsp_valid, rsp_err, rsp_data}, {1'b1, exp_e, exp_d});
    end
    rsp_ready = 1;
    @(posedge ACLK);
    #1 rsp_ready = 0;
    @(negedge ACLK);
    check({tag, "_back_idle"}, {rsp_valid, req_ready}, 2'b01);
  endtask

  task automatic check_writes(input string tag, input int n_exp);
    check({tag, "_wr_cnt"}, wr_cnt, n_exp);
    for (int i = 0; i < n_exp; i++)
      check($sformatf("%s_wr%0d", tag, i), {wr_addr[i], wr_data[i]}, {exp_wa[i], exp_wd[i]});
  endtask

  task automatic check_reads(input string tag, input int n_stat, input int n_dout);
    check({tag, "_rd_cnt"}, rd_cnt, n_stat + n_dout);
    for (int i = 0; i < n_stat; i++)
      check($sformatf("%s_stat%0d", tag, i), rd_addr[i], c_BASE + 32'h24);
    for (int i = 0; i < n_dout; i++)
      check($sformatf("%s_dout%0d", tag, i), rd_addr[n_stat + i], c_BASE + 32'h30 + 32'(4 * i));
  endtask

  initial begin : main
    int n;
    for (int i = 0; i < 9; i++) exp_wa[i] = c_BASE + 32'(4 * i);
    exp_wd[0] = 32'h0c0d0e0f; exp_wd[1] = 32'h08090a0b;
    exp_wd[2] = 32'h04050607; exp_wd[3] = 32'h00010203;
    exp_wd[4] = 32'hccddeeff; exp_wd[5] = 32'h8899aabb;
    exp_wd[6] = 32'h44556677; exp_wd[7] = 32'h00112233;
    exp_wd[8] = 32'h00000001;

    // reset state
    repeat (3) @(negedge ACLK);
    check("rst_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 5'b0);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_data, req_ready}, '0);
    check("rst_addr", {AWADDR, ARADDR, WDATA}, '0);
    ARST = 0;

    // A: zero-wait slave, done on first poll; 14 transactions -> rsp at cycle 29
    clear_logs();
    run_job("basic", ct, 1'b0, 29, 0);
    check_writes("basic", 9);
    check_reads("basic", 1, 4);
    check("basic_wstrb", wstrb_bad, 0);

    // B: WREADY three cycles ahead of AWREADY on every write
    w_early = 1; clear_logs();
    run_job("wearly", ct, 1'b0, -1, 0);
    check_writes("wearly", 9);
    check_reads("wearly", 1, 4);
    w_early = 0;

    // C: done only on the 5th STAT read
    done_on = 5; clear_logs();
    run_job("poll5", ct, 1'b0, -1, 0);
    check("poll5_stat", stat_reads, 5);
    check_reads("poll5", 5, 4);
    done_on = 1;

    // D: error response on the CTRL write
    bresp_ctrl_err = 1; clear_logs();
    run_job("berr", 128'h0, 1'b1, -1, 0);
    check_writes("berr", 9);
    check("berr_rd_cnt", rd_cnt, 0);
    bresp_ctrl_err = 0;

    // E: done never set -> timeout after POLL_MAX reads, nothing read afterwards
    done_on = 0; clear_logs();
    run_job("tmo", 128'h0, 1'b1, -1, 0);
    repeat (5) @(negedge ACLK);
    check("tmo_stat", stat_reads, c_PMAX);
    check("tmo_rd_cnt", rd_cnt, c_PMAX);
    done_on = 1;

    // F: consumer stalls for 10 cycles
    clear_logs();
    run_job("hold", ct, 1'b0, -1, 10);

    // G: reset pulse during a DIN write, then a clean job
    clear_logs();
    @(negedge ACLK);
    req_key = key_v; req_data = pt_v; req_valid = 1;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge ACLK); n++; end
    @(posedge ACLK);
    #1 req_valid = 0;
    n = 0;
    @(negedge ACLK);
    while (!(AWVALID && AWADDR == c_BASE + 32'h14) && n < 200) begin @(negedge ACLK); n++; end
    check("arst_reached_din", {AWVALID, AWADDR}, {1'b1, c_BASE + 32'h14});
    ARST = 1;
    #1;
    check("arst_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, req_ready}, 7'b0);
    repeat (2) @(negedge ACLK);
    ARST = 0;
    repeat (2) @(negedge ACLK);
    clear_logs();
    run_job("after_rst", ct, 1'b0, 29, 0);
    check_writes("after_rst", 9);
    check_reads("after_rst", 1, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
